tdpram_port_arbiter: RTL

//  Round-robin arbiter that shares one port of the true-dual-port RAM (tdpram) between NREQ requesters.

---
 rtl/tdpram_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/tdpram_port_arbiter.sv
// Round-robin arbiter that shares one tdpram port between NREQ requesters.
// It issues one registered RAM access per cycle and routes each read result back to its requester.
module tdpram_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 36,
    parameter int REG       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ*ADDR_BITS-1:0] req_addr,
    input  logic [NREQ*DATA_BITS-1:0] req_wdata,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DATA_BITS-1:0]      rsp_data,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_BITS-1:0]      ram_addr,
    output logic [DATA_BITS-1:0]      ram_din,
    input  logic [DATA_BITS-1:0]      ram_dout
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int DEPTH = 1 + REG;

    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_found;
    logic                   handshake;

    logic                   ram_en_q, ram_en_d;
    logic                   ram_we_q, ram_we_d;
    logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_BITS-1:0]   ram_din_q, ram_din_d;

    logic [DEPTH-1:0]       tag_rd_q, tag_rd_d;
    logic [DEPTH*IDX_W-1:0] tag_id_q, tag_id_d;
    logic [IDX_W-1:0]       tag_id_last;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;

    // Search req_valid starting at the pointer and wrapping; the first hit wins.
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
    end

    // A request is accepted on a rising edge where req_valid[g] and req_ready[g] are both high;
    // the requester keeps valid/we/addr/wdata stable until then and must always take responses.
    assign handshake = grant_found && rst_n;
    assign req_ready = handshake ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        ptr_d      = ptr_q;
        ram_en_d   = 1'b1;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if (handshake) begin
            ptr_d      = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
            ram_we_d   = req_we[grant_idx];
            ram_addr_d = req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
            ram_din_d  = req_wdata[grant_idx*DATA_BITS +: DATA_BITS];
        end
    end

    // Tag pipeline matches the RAM read latency so rsp_valid lines up with ram_dout.
    assign tag_id_last = tag_id_q[(DEPTH-1)*IDX_W +: IDX_W];

    always_comb begin
        tag_rd_d    = (tag_rd_q << 1) | DEPTH'(handshake && !req_we[grant_idx]);
        tag_id_d    = (tag_id_q << IDX_W) | (DEPTH*IDX_W)'(grant_idx);
        rsp_valid_d = tag_rd_q[DEPTH-1] ? (NREQ'(1) << tag_id_last) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            tag_rd_q    <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            tag_rd_q    <= tag_rd_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = ram_dout;

endmodule
